shared_res_arbiter: RTL and testbench



---
 rtl/shared_res_arbiter.sv | 133 +++++++++++++
 tb/tb_shared_res_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/shared_res_arbiter.sv
// Round-robin owner arbitration for one shared single-bit resource, with an
// optional hold timeout and steering of the owner's data bit onto RES_IN.
module shared_res_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         REQ,
  input  logic [NREQ-1:0]         DIN,
  output logic [NREQ-1:0]         GNT,
  output logic [$clog2(NREQ)-1:0] GNT_ID,
  output logic                    BUSY,
  output logic                    TIMEOUT,
  output logic                    RES_IN
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]  HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE      = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [IDW-1:0]  last_q, last_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [IDW-1:0]  win_id;
  logic            win_found;

  // Search from last+1 upward with wrap; the index is reduced by subtraction
  // so a non-power-of-two NREQ never yields an out-of-range candidate.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_id;
    win_id    = '0;
    win_found = 1'b0;
    idx       = 0;
    idx_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_id = idx[IDW-1:0];
      if (!win_found && REQ[idx_id]) begin
        win_found = 1'b1;
        win_id    = idx_id;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    last_d    = last_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE, S_RELEASE: begin
        if (win_found) begin
          state_d  = S_GRANT;
          gnt_d    = ONE << win_id;
          gnt_id_d = win_id;
          last_d   = win_id;
          busy_d   = 1'b1;
          cnt_d    = '0;
        end else begin
          state_d = S_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      S_GRANT: begin
        if (!REQ[gnt_id_q]) begin
          state_d = S_RELEASE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if ((MAX_HOLD != 0) && (cnt_q == HOLD_LAST)) begin
          // Preempted owner stays in last_q so it ranks lowest next time.
          state_d   = S_RELEASE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      last_q    <= LAST_ID;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign GNT     = gnt_q;
  assign GNT_ID  = gnt_id_q;
  assign BUSY    = busy_q;
  assign TIMEOUT = timeout_q;
  assign RES_IN  = busy_q & DIN[gnt_id_q];

endmodule

// File: tb/tb_shared_res_arbiter.sv
// Randomized bench for shared_res_arbiter: three instances (4/8, 4/no-timeout,
// 3/3) compared every cycle against an owner/priority reference model.
module tb_shared_res_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] req_a, din_a, gnt_a, req_b, din_b, gnt_b;
  logic [2:0] req_c, din_c, gnt_c;
  logic [1:0] gid_a, gid_b, gid_c;
  logic       busy_a, busy_b, busy_c, to_a, to_b, to_c, res_a, res_b, res_c;

  shared_res_arbiter #(.NREQ(4), .MAX_HOLD(8)) u_dut_a (
    .CLK(clk), .RST(rst_n), .REQ(req_a), .DIN(din_a), .GNT(gnt_a),
    .GNT_ID(gid_a), .BUSY(busy_a), .TIMEOUT(to_a), .RES_IN(res_a));
  shared_res_arbiter #(.NREQ(4), .MAX_HOLD(0)) u_dut_b (
    .CLK(clk), .RST(rst_n), .REQ(req_b), .DIN(din_b), .GNT(gnt_b),
    .GNT_ID(gid_b), .BUSY(busy_b), .TIMEOUT(to_b), .RES_IN(res_b));
  shared_res_arbiter #(.NREQ(3), .MAX_HOLD(3)) u_dut_c (
    .CLK(clk), .RST(rst_n), .REQ(req_c), .DIN(din_c), .GNT(gnt_c),
    .GNT_ID(gid_c), .BUSY(busy_c), .TIMEOUT(to_c), .RES_IN(res_c));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current owner (-1 = none), priority pointer, cycles owned.
  int own[3];
  int lst[3];
  int held[3];
  int gidm[3];
  bit tom[3];
  bit b_auto;

  function automatic int nr(input int i);
    return (i == 2) ? 3 : 4;
  endfunction

  function automatic int mh(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 0 : 3);
  endfunction

  function automatic logic [31:0] req_of(input int i);
    return (i == 0) ? 32'(req_a) : ((i == 1) ? 32'(req_b) : 32'(req_c));
  endfunction

  function automatic logic [31:0] din_of(input int i);
    return (i == 0) ? 32'(din_a) : ((i == 1) ? 32'(din_b) : 32'(din_c));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      own[i] = -1; lst[i] = nr(i) - 1; held[i] = 0; gidm[i] = 0; tom[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    logic [31:0] r;
    int cand;
    r = req_of(i);
    tom[i] = 0;
    if (own[i] >= 0) begin
      if (!r[own[i]]) own[i] = -1;
      else if (mh(i) != 0 && held[i] == mh(i)) begin
        own[i] = -1;
        tom[i] = 1;
      end else held[i]++;
    end else begin
      for (int k = 1; k <= nr(i); k++) begin
        cand = (lst[i] + k) % nr(i);
        if (own[i] < 0 && r[cand]) begin
          own[i] = cand; lst[i] = cand; gidm[i] = cand; held[i] = 1;
        end
      end
    end
  endtask

  task automatic check_inst(input int i);
    logic [31:0] g, id, b, t, r, d, eg, er;
    case (i)
      0: begin g = 32'(gnt_a); id = 32'(gid_a); b = 32'(busy_a); t = 32'(to_a); r = 32'(res_a); end
      1: begin g = 32'(gnt_b); id = 32'(gid_b); b = 32'(busy_b); t = 32'(to_b); r = 32'(res_b); end
      default: begin g = 32'(gnt_c); id = 32'(gid_c); b = 32'(busy_c); t = 32'(to_c); r = 32'(res_c); end
    endcase
    d  = din_of(i);
    eg = (own[i] >= 0) ? (32'd1 << own[i]) : 32'd0;
    er = (own[i] >= 0) ? 32'(d[own[i]]) : 32'd0;
    check($sformatf("gnt%0d", i), g, eg);
    check($sformatf("gnt_id%0d", i), id, 32'(gidm[i]));
    check($sformatf("busy%0d", i), b, 32'(own[i] >= 0));
    check($sformatf("timeout%0d", i), t, 32'(tom[i]));
    check($sformatf("res_in%0d", i), r, er);
  endtask

  // One clock: new DIN, optional auto fairness pattern on B, model, then check.
  task automatic tick();
    din_a = 4'($urandom); din_b = 4'($urandom); din_c = 3'($urandom);
    if (b_auto) begin
      req_b = 4'b1111;
      if (own[1] >= 0 && held[1] == 3) req_b[own[1]] = 1'b0;
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_inst(i);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 for (int i = 0; i < 3; i++) check_inst(i);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_inst(i);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_req(input int i);
    logic [31:0] r;
    r = 0;
    for (int k = 0; k < nr(i); k++)
      r[k] = (k == own[i]) ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    din_a = '0; din_b = '0; din_c = '0;
    b_auto = 1'b0;
    model_reset();
    #12;
    for (int i = 0; i < 3; i++) check_inst(i);
    @(negedge clk);
    rst_n  = 1'b1;
    b_auto = 1'b1;

    // First grant and NREQ=3 wrap (owner 2 releases with 3'b011 pending)
    req_a = 4'b1010; req_c = 3'b100;
    tick();
    req_c = 3'b011;
    repeat (3) tick();

    // Constant 0101 on A: timeouts alternate between requesters 0 and 2
    req_a = 4'b0101;
    repeat (30) tick();

    // Owner drops REQ on its 8th held cycle
    req_a = 4'b0000;
    repeat (2) tick();
    req_a = 4'b0001;
    repeat (8) tick();
    req_a = 4'b0000;
    repeat (2) tick();

    // Reset between edges while requester 3 owns A
    req_a = 4'b1000;
    repeat (2) tick();
    async_reset();
    req_a = 4'b1001;
    repeat (3) tick();

    // Randomized traffic on all instances
    b_auto = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      req_a = 4'(rand_req(0));
      req_b = 4'(rand_req(1));
      req_c = 3'(rand_req(2));
      tick();
      if (n == 700) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
